// File: rtl/sc_imem_loader.sv
// Boot-time instruction memory: assembles a framed, checksummed byte stream into RAM
// and releases the CPU from reset once a complete, valid image has been accepted.
module sc_imem_loader #(
    parameter int AW = 6
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          rx_valid,
    input  logic [7:0]    rx_byte,
    input  logic [31:0]   pc,
    output logic [31:0]   inst,
    output logic          cpu_resetn,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   wcount
);

    localparam int         DEPTH = 1 << AW;
    localparam logic [7:0] HDR   = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        RUN,
        ERR
    } state_t;

    state_t        state;
    logic [AW:0]   nwords;
    logic [1:0]    lane;
    logic [AW-1:0] waddr;
    logic [7:0]    acc;
    logic [23:0]   asm_lo;

    logic [31:0]   mem [DEPTH];

    logic          cnt_ok;
    logic          wr_en;
    logic          last_word;
    logic [31:0]   word_full;
    logic          unused_pc;

    // Lanes 0..2 are buffered; the lane-3 byte completes the word straight from the input.
    assign word_full = {rx_byte, asm_lo};
    assign wr_en     = rx_valid && (state == DATA) && (lane == 2'd3);
    assign last_word = (wcount == nwords - 1'b1);
    assign cnt_ok    = (rx_byte != 8'd0) && (int'(rx_byte) <= DEPTH);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[waddr] <= word_full;
        end
    end

    // Only word-address bits of pc select the RAM word; the rest wrap or are byte offsets.
    assign unused_pc = ^{pc[31:AW+2], pc[1:0]};
    assign inst      = (state == RUN) ? mem[pc[AW+1:2]] : 32'h0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            nwords     <= '0;
            lane       <= '0;
            waddr      <= '0;
            wcount     <= '0;
            acc        <= '0;
            asm_lo     <= '0;
            cpu_resetn <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_byte == HDR) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (cnt_ok) begin
                        nwords <= (AW+1)'(rx_byte);
                        lane   <= '0;
                        waddr  <= '0;
                        wcount <= '0;
                        acc    <= '0;
                        state  <= DATA;
                    end else begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end
                end
                DATA: begin
                    acc  <= acc ^ rx_byte;
                    lane <= lane + 2'd1;
                    if (lane != 2'd3) begin
                        asm_lo[{lane, 3'b000} +: 8] <= rx_byte;
                    end else begin
                        waddr  <= waddr + 1'b1;
                        wcount <= wcount + 1'b1;
                        if (last_word) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (rx_byte == acc) begin
                        state      <= RUN;
                        load_done  <= 1'b1;
                        cpu_resetn <= 1'b1;
                    end else begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                ERR: begin
                    if (rx_byte == HDR) begin
                        state    <= COUNT;
                        load_err <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_imem_loader.sv
// Bench for sc_imem_loader: directed frame table, hand-written corner sequences and
// random frame streams compared against a frame-level parser model.
module tb_sc_imem_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic [31:0]   pc = 32'h0;
    logic [31:0]   inst;
    logic          cpu_resetn;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   wcount;

    sc_imem_loader #(.AW(AW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .pc         (pc),
        .inst       (inst),
        .cpu_resetn (cpu_resetn),
        .load_done  (load_done),
        .load_err   (load_err),
        .wcount     (wcount)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] txq[$];
    logic [7:0] hist[$];

    bit [31:0] m_mem [DEPTH];
    bit        m_vld [DEPTH];
    bit        m_run;
    bit        m_err;
    int        m_wc;

    typedef struct {
        logic [7:0] n;
        logic [7:0] xmask;
        logic       exp_done;
        logic       exp_err;
        int         exp_wc;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Frame-level view of every byte received since reset: find headers, take N words,
    // compare the XOR checksum. Words completed before a truncation are still recorded.
    task automatic run_model();
        int         i;
        int         n;
        logic [7:0] acc;
        i = 0; m_run = 0; m_err = 0; m_wc = 0;
        while (i < hist.size() && !m_run) begin
            if (hist[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            m_err = 0;
            if (i >= hist.size()) break;
            n = int'(hist[i]);
            i++;
            if (n == 0 || n > DEPTH) begin
                m_err = 1;
                continue;
            end
            m_wc = 0;
            acc  = 8'h00;
            for (int w = 0; w < n && i + 4 <= hist.size(); w++) begin
                m_mem[w] = {hist[i+3], hist[i+2], hist[i+1], hist[i]};
                m_vld[w] = 1'b1;
                acc = acc ^ hist[i] ^ hist[i+1] ^ hist[i+2] ^ hist[i+3];
                m_wc++;
                i += 4;
            end
            if (m_wc != n || i >= hist.size()) break;
            if (hist[i] == acc) m_run = 1;
            else                m_err = 1;
            i++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_byte  = b;
        hist.push_back(b);
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic send_q(input bit gaps);
        foreach (txq[k]) begin
            send_byte(txq[k]);
            if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
        end
        txq.delete();
        idle_cycle();
    endtask

    task automatic do_reset();
        run_model();
        hist.delete();
        @(negedge clock);
        rx_valid = 1'b0;
        resetn   = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    function automatic logic [7:0] pat(input int w, input int j);
        return 8'(w * 29 + j * 7 + 19);
    endfunction

    function automatic logic [31:0] pword(input int w);
        return {pat(w, 3), pat(w, 2), pat(w, 1), pat(w, 0)};
    endfunction

    task automatic push_frame(input int n, input logic [7:0] xm, input bit rnd);
        logic [7:0] acc;
        logic [7:0] b;
        acc = 8'h00;
        txq.push_back(8'hA5);
        txq.push_back(8'(n));
        for (int w = 0; w < n; w++) begin
            for (int j = 0; j < 4; j++) begin
                b = rnd ? 8'($urandom) : pat(w, j);
                acc ^= b;
                txq.push_back(b);
            end
        end
        txq.push_back(acc ^ xm);
    endtask

    task automatic check_inst(input string name, input logic [31:0] p, input logic [31:0] exp);
        @(negedge clock);
        pc = p;
        #1;
        check(name, inst, exp);
    endtask

    task automatic check_model(input string tag);
        run_model();
        check({tag, " load_done"},  {31'b0, load_done},  {31'b0, m_run});
        check({tag, " cpu_resetn"}, {31'b0, cpu_resetn}, {31'b0, m_run});
        check({tag, " load_err"},   {31'b0, load_err},   {31'b0, m_err});
        check({tag, " wcount"},     32'(wcount),         32'(m_wc));
        if (m_run) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (m_vld[a]) check_inst({tag, " inst"}, {24'($urandom), 6'(a), 2'($urandom)}, m_mem[a]);
            end
        end else begin
            check_inst({tag, " inst nop"}, $urandom, 32'h0);
        end
    endtask

    initial begin
        logic [7:0] g;
        int         kind;
        int         n;

        tbl[0] = '{8'd1,  8'h00, 1'b1, 1'b0, 1};
        tbl[1] = '{8'd3,  8'h00, 1'b1, 1'b0, 3};
        tbl[2] = '{8'd64, 8'h00, 1'b1, 1'b0, 64};
        tbl[3] = '{8'd0,  8'h00, 1'b0, 1'b1, 0};
        tbl[4] = '{8'd65, 8'h00, 1'b0, 1'b1, 0};
        tbl[5] = '{8'd2,  8'h01, 1'b0, 1'b1, 2};
        tbl[6] = '{8'd64, 8'h80, 1'b0, 1'b1, 64};
        tbl[7] = '{8'd255,8'h00, 1'b0, 1'b1, 0};

        // Reset state
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1;
        check("rst cpu_resetn", {31'b0, cpu_resetn}, 32'h0);
        check("rst load_done",  {31'b0, load_done},  32'h0);
        check("rst load_err",   {31'b0, load_err},   32'h0);
        check("rst wcount",     32'(wcount),         32'h0);
        check("rst inst",       inst,                32'h0);

        // Single-word image
        txq = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h01, 8'h20, 8'h32};
        send_q(0);
        check("one load_done",  {31'b0, load_done},  32'h1);
        check("one cpu_resetn", {31'b0, cpu_resetn}, 32'h1);
        check("one wcount",     32'(wcount),         32'h1);
        check_inst("one inst", 32'h0, 32'h20010013);

        // Traffic in RUN is ignored
        txq = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_q(0);
        check("run ignore wcount", 32'(wcount), 32'h1);
        check("run ignore done",   {31'b0, load_done}, 32'h1);
        check_inst("run ignore inst", 32'h0, 32'h20010013);

        // Asynchronous reset drops cpu_resetn between edges
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async cpu_resetn", {31'b0, cpu_resetn}, 32'h0);
        check("async inst",       inst,                32'h0);
        run_model();
        hist.delete();
        @(negedge clock);
        resetn = 1'b1;

        // Three words back-to-back, address wrap
        push_frame(3, 8'h00, 0);
        send_q(0);
        check("n3 load_done", {31'b0, load_done}, 32'h1);
        check_inst("n3 pc0",   32'h0,   pword(0));
        check_inst("n3 pc4",   32'h4,   pword(1));
        check_inst("n3 pc8",   32'h8,   pword(2));
        check_inst("n3 pc100", 32'h100, pword(0));
        check_inst("n3 pc10b", 32'h10B, pword(2));

        // Bad checksum then recovery
        do_reset();
        push_frame(2, 8'h01, 0);
        send_q(0);
        check("badcs load_err",   {31'b0, load_err},   32'h1);
        check("badcs cpu_resetn", {31'b0, cpu_resetn}, 32'h0);
        check_inst("badcs inst", 32'h4, 32'h0);
        push_frame(2, 8'h00, 1);
        send_q(1);
        check_model("recover");
        check("recover load_err", {31'b0, load_err}, 32'h0);

        // Invalid count bytes
        for (int k = 0; k < 2; k++) begin
            do_reset();
            txq = '{8'hA5, (k == 0) ? 8'h00 : 8'h41};
            send_q(0);
            check($sformatf("badn%0d load_err", k), {31'b0, load_err}, 32'h1);
            check($sformatf("badn%0d wcount", k),   32'(wcount),       32'h0);
        end

        // Reset in the middle of DATA, then a full reload
        do_reset();
        txq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_q(0);
        check("mid wcount before", 32'(wcount), 32'h1);
        do_reset();
        check("mid cpu_resetn", {31'b0, cpu_resetn}, 32'h0);
        check("mid wcount",     32'(wcount),         32'h0);
        push_frame(2, 8'h00, 1);
        send_q(0);
        check_model("reload");

        // Header value appearing as data and as checksum
        do_reset();
        txq = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
        send_q(0);
        check_model("a5data");
        do_reset();
        txq = '{8'hA5, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5};
        send_q(0);
        check_model("a5cs");

        // Directed frame table
        for (int t = 0; t < 8; t++) begin
            do_reset();
            if (tbl[t].n != 0 && int'(tbl[t].n) <= DEPTH) begin
                push_frame(int'(tbl[t].n), tbl[t].xmask, 0);
            end else begin
                txq = '{8'hA5, tbl[t].n};
            end
            send_q(0);
            check($sformatf("tbl%0d load_done", t),  {31'b0, load_done},  {31'b0, tbl[t].exp_done});
            check($sformatf("tbl%0d cpu_resetn", t), {31'b0, cpu_resetn}, {31'b0, tbl[t].exp_done});
            check($sformatf("tbl%0d load_err", t),   {31'b0, load_err},   {31'b0, tbl[t].exp_err});
            check($sformatf("tbl%0d wcount", t),     32'(wcount),         32'(tbl[t].exp_wc));
            if (tbl[t].exp_done) begin
                check_inst($sformatf("tbl%0d inst0", t), 32'h0, pword(0));
                check_inst($sformatf("tbl%0d instlast", t), 32'((tbl[t].exp_wc - 1) * 4),
                           pword(tbl[t].exp_wc - 1));
            end else begin
                check_inst($sformatf("tbl%0d inst", t), 32'h0, 32'h0);
            end
        end

        // Random streams
        for (int r = 0; r < 20; r++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                txq.push_back(g);
            end
            kind = $urandom_range(0, 2);
            if (kind == 1) begin
                txq.push_back(8'hA5);
                txq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255)));
            end else if (kind == 2) begin
                push_frame($urandom_range(1, 8), 8'($urandom_range(1, 255)), 1);
            end
            n = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 64) : $urandom_range(1, 4);
            push_frame(n, 8'h00, 1);
            if ($urandom_range(0, 3) == 0) push_frame(1, 8'h00, 1);
            send_q(1);
            check_model($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
